// File: rtl/cdc_pulse_tx_pkg.sv
// Shared helpers for the toggle-based pulse crossing (source side).
package cdc_pulse_tx_pkg;

  // Width of a down-counter loaded with n-1; never narrower than one bit.
  function automatic int hold_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Plain multi-flop synchroniser for a slow-changing level. It has no reset:
// the chain settles on its own after a few clocks.
module cdc_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous level through STAGES flops.
  always_ff @(posedge clk) begin
    sync_q[0] <= d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_pulse_tx.sv
// Source end of the toggle pulse crossing: each ipulse becomes one flip of
// otoggle. Levels are held at least HOLD_CYCLES clocks so the receiver can
// sample them; events arriving during a hold are queued in a counter.
// Optional macro CDC_PULSE_TX_ACK_EN adds the iack return path so that a new
// flip also waits for the previous level to be seen by the destination.
//
// Handshake: ipulse is a one-cycle strobe with no back-pressure; when the
// queue is full the event is dropped and ooverflow pulses for one cycle.
module cdc_pulse_tx
  import cdc_pulse_tx_pkg::*;
#(
  parameter int HOLD_CYCLES   = 4,
  parameter int PENDING_WIDTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     sreset,
  input  logic                     ipulse,
`ifdef CDC_PULSE_TX_ACK_EN
  input  logic                     iack,
`endif
  output logic                     otoggle,
  output logic                     obusy,
  output logic [PENDING_WIDTH-1:0] opending,
  output logic                     ooverflow
);

  localparam int HOLD_W = hold_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]        HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX  = '1;

  logic                     toggle_q, toggle_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [PENDING_WIDTH-1:0] pending_q, pending_d;
  logic                     ovf_q, ovf_d;
  logic                     ack_ok;
  logic                     can_send, want, flip;

`ifdef CDC_PULSE_TX_ACK_EN
  logic ack_s;

  cdc_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_ack_sync (
    .clk (clk),
    .d_i (iack),
    .q_o (ack_s)
  );

  // The last level sent has come back through the destination.
  assign ack_ok = (ack_s == toggle_q);
`else
  localparam int unused_sync_stages = SYNC_STAGES;
  assign ack_ok = 1'b1;
`endif

  // Decide whether this edge flips and compute every next-state value.
  always_comb begin
    can_send  = (hold_q == '0) && ack_ok;
    want      = ipulse || (pending_q != '0);
    flip      = want && can_send;
    toggle_d  = toggle_q;
    hold_d    = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    pending_d = pending_q;
    ovf_d     = 1'b0;
    if (flip) begin
      toggle_d = ~toggle_q;
      hold_d   = HOLD_LOAD;
    end
    if (ipulse && !flip) begin
      if (pending_q != PEND_MAX) pending_d = pending_q + PENDING_WIDTH'(1);
      else                       ovf_d     = 1'b1;
    end else if (!ipulse && flip) begin
      pending_d = pending_q - PENDING_WIDTH'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sreset) begin
      toggle_q  <= 1'b0;
      hold_q    <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign otoggle   = toggle_q;
  assign ooverflow = ovf_q;
  assign opending  = pending_q;
  assign obusy     = (pending_q != '0) || (hold_q != '0);

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// Directed bench for cdc_pulse_tx: a HOLD_CYCLES=4 instance and a
// HOLD_CYCLES=1 instance, both with PENDING_WIDTH=2.
module tb_cdc_pulse_tx;

  logic       clk = 1'b0;
  logic       sreset = 1'b1;
  logic       ipulse = 1'b0;
  logic       ipulse_h1 = 1'b0;
  logic       otoggle, obusy, ooverflow;
  logic [1:0] opending;
  logic       otoggle_h1, obusy_h1, ooverflow_h1;
  logic [1:0] opending_h1;

  int checks = 0;
  int errors = 0;

  // clock
  always #5 clk = ~clk;

  cdc_pulse_tx #(.HOLD_CYCLES(4), .PENDING_WIDTH(2), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .sreset    (sreset),
    .ipulse    (ipulse),
    .otoggle   (otoggle),
    .obusy     (obusy),
    .opending  (opending),
    .ooverflow (ooverflow)
  );

  cdc_pulse_tx #(.HOLD_CYCLES(1), .PENDING_WIDTH(2), .SYNC_STAGES(2)) dut_h1 (
    .clk       (clk),
    .sreset    (sreset),
    .ipulse    (ipulse_h1),
    .otoggle   (otoggle_h1),
    .obusy     (obusy_h1),
    .opending  (opending_h1),
    .ooverflow (ooverflow_h1)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    sreset = 1'b1; ipulse = 1'b0; ipulse_h1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (otoggle !== 1'b0 || obusy !== 1'b0 || opending !== 2'd0 || ooverflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tog=%b busy=%b pend=%0d ovf=%b, want 0 0 0 0",
               otoggle, obusy, opending, ooverflow);
    end
  endtask

  // Single pulse: flip at E, busy for 3 cycles.
  task automatic test_single();
    logic exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    ipulse = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ipulse = 1'b0;
      checks++;
      if (otoggle !== 1'b1 || obusy !== exp_busy[k] || opending !== 2'd0 || ooverflow !== 1'b0) begin
        errors++;
        $display("FAIL single[%0d]: tog=%b busy=%b pend=%0d ovf=%b, want 1 %b 0 0",
                 k, otoggle, obusy, opending, ooverflow, exp_busy[k]);
      end
    end
  endtask

  // Three back-to-back pulses: flips at E, E+4, E+8.
  task automatic test_back_to_back();
    logic       exp_t [11] = '{1,1,1,1,0,0,0,0,1,1,1};
    logic [1:0] exp_p [11] = '{0,1,2,2,1,1,1,1,0,0,0};
    do_reset();
    for (int k = 0; k < 11; k++) begin
      ipulse = (k < 3);
      @(negedge clk);
      checks++;
      if (otoggle !== exp_t[k] || opending !== exp_p[k] || ooverflow !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: tog=%b pend=%0d ovf=%b, want %b %0d 0",
                 k, otoggle, opending, ooverflow, exp_t[k], exp_p[k]);
      end
    end
    ipulse = 1'b0;
  endtask

  // Six pulses into a 3-deep queue: sixth is dropped, five flips total.
  task automatic test_overflow();
    logic       exp_t [20] = '{1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
    logic [1:0] exp_p [20] = '{0,1,2,3,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0};
    logic       prev_t;
    int         flips;
    do_reset();
    prev_t = 1'b0;
    flips  = 0;
    for (int k = 0; k < 20; k++) begin
      ipulse = (k < 6);
      @(negedge clk);
      if (otoggle !== prev_t) flips++;
      prev_t = otoggle;
      checks++;
      if (otoggle !== exp_t[k] || opending !== exp_p[k] || ooverflow !== (k == 5)) begin
        errors++;
        $display("FAIL ovf[%0d]: tog=%b pend=%0d ovf=%b, want %b %0d %b",
                 k, otoggle, opending, ooverflow, exp_t[k], exp_p[k], (k == 5));
      end
    end
    ipulse = 1'b0;
    checks++;
    if (flips != 5) begin
      errors++;
      $display("FAIL ovf_flip_count: got %0d, want 5", flips);
    end
  endtask

  // Reset while mid-hold with two queued events.
  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ipulse = 1'b1;
      @(negedge clk);
    end
    ipulse = 1'b0;
    checks++;
    if (otoggle !== 1'b1 || opending !== 2'd2) begin
      errors++;
      $display("FAIL midrst_pre: tog=%b pend=%0d, want 1 2", otoggle, opending);
    end
    sreset = 1'b1;
    @(negedge clk);
    sreset = 1'b0;
    checks++;
    if (otoggle !== 1'b0 || opending !== 2'd0 || obusy !== 1'b0 || ooverflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: tog=%b pend=%0d busy=%b ovf=%b, want 0 0 0 0",
               otoggle, opending, obusy, ooverflow);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (otoggle !== 1'b0 || obusy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle[%0d]: tog=%b busy=%b, want 0 0", k, otoggle, obusy);
      end
    end
  endtask

  // HOLD_CYCLES=1: one flip per cycle, no queueing.
  task automatic test_hold_one();
    logic exp_t;
    do_reset();
    exp_t = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ipulse_h1 = (k < 8);
      @(negedge clk);
      if (k < 8) exp_t = ~exp_t;
      checks++;
      if (otoggle_h1 !== exp_t || opending_h1 !== 2'd0 || ooverflow_h1 !== 1'b0 || obusy_h1 !== 1'b0) begin
        errors++;
        $display("FAIL hold1[%0d]: tog=%b pend=%0d ovf=%b busy=%b, want %b 0 0 0",
                 k, otoggle_h1, opending_h1, ooverflow_h1, obusy_h1, exp_t);
      end
    end
    ipulse_h1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_hold_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
